// File: rtl/shl_seq_if.sv
// Valid/ready request and response bundle for the sequential left-shift engine.
// With SHL_SEQ_ROTL_EN defined, the request also carries in_rot.
interface shl_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned AMT_W = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
`ifdef SHL_SEQ_ROTL_EN
  logic             in_rot;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid,
`ifdef SHL_SEQ_ROTL_EN
    output in_rot,
`endif
    output in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid,
`ifdef SHL_SEQ_ROTL_EN
    input  in_rot,
`endif
    input  in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shl_seq.sv
// Multi-cycle logical left shifter: up to STEP bits per cycle, valid/ready on both sides.
// Optional SHL_SEQ_ROTL_EN adds a per-request left-rotate mode selected by in_rot.
module shl_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  shl_seq_if.slave     bus
);
  localparam int unsigned AMT_W = $clog2(WIDTH) + 1;

  if (STEP < 1 || STEP > WIDTH || (STEP & (STEP - 1)) != 0) begin : g_bad_step
    $error("shl_seq: STEP must be a power of two in 1..WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [AMT_W-1:0] r_rem;
  logic [AMT_W-1:0] w_rem_nxt;
  logic [AMT_W-1:0] w_step;
  logic [AMT_W-1:0] w_ld_rem;
  logic [WIDTH-1:0] w_stepped;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic             w_busy_nxt;
`ifdef SHL_SEQ_ROTL_EN
  logic             r_rot;
  logic             w_rot_nxt;
`endif

  // Clamp the requested amount at load: beyond WIDTH the shifted word is all zeros.
`ifdef SHL_SEQ_ROTL_EN
  always_comb begin
    w_ld_rem = (bus.in_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.in_amt;
    if (bus.in_rot) begin
      w_ld_rem = AMT_W'(bus.in_amt % AMT_W'(WIDTH));
    end
  end
`else
  assign w_ld_rem = (bus.in_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.in_amt;
`endif

  assign w_step = (r_rem > AMT_W'(STEP)) ? AMT_W'(STEP) : r_rem;

  // One step of the datapath; w_step is non-zero whenever this is used.
`ifdef SHL_SEQ_ROTL_EN
  always_comb begin
    w_stepped = r_data << w_step;
    if (r_rot) begin
      w_stepped = (r_data << w_step) | (r_data >> (AMT_W'(WIDTH) - w_step));
    end
  end
`else
  assign w_stepped = r_data << w_step;
`endif

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_rem_nxt   = r_rem;
`ifdef SHL_SEQ_ROTL_EN
    w_rot_nxt   = r_rot;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_data_nxt  = bus.in_data;
          w_rem_nxt   = w_ld_rem;
`ifdef SHL_SEQ_ROTL_EN
          w_rot_nxt   = bus.in_rot;
`endif
          w_state_nxt = (w_ld_rem == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_data_nxt = w_stepped;
        w_rem_nxt  = r_rem - w_step;
        if (r_rem == w_step) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State, datapath and handshake flags, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_rem       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SHL_SEQ_ROTL_EN
      r_rot       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_rem       <= w_rem_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
`ifdef SHL_SEQ_ROTL_EN
      r_rot       <= w_rot_nxt;
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_data;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_shl_seq.sv
// Randomized and directed check of shl_seq against a plain-arithmetic shift/rotate model.
module tb_shl_seq;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEP  = 4;
`ifdef SHL_SEQ_ROTL_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  shl_seq_if #(.WIDTH(WIDTH)) u_if ();

  shl_seq #(.WIDTH(WIDTH), .STEP(STEP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_result(logic [31:0] d, int amt, bit rot);
    logic [63:0] dd;
    if (rot) begin
      dd = {d, d} << (amt % 32);
      return dd[63:32];
    end
    if (amt >= 32) return 32'h0;
    return d << amt;
  endfunction

  function automatic int model_latency(int amt, bit rot);
    int rem;
    rem = rot ? (amt % 32) : ((amt > 32) ? 32 : amt);
    return 1 + (rem + STEP - 1) / STEP;
  endfunction

  // Present one request and complete the accept edge; inputs are scrambled afterwards.
  task automatic accept(input logic [31:0] d, input int amt, input bit rot);
    check("in_ready_before_accept", 64'(u_if.in_ready), 64'd1);
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    u_if.in_amt   = 6'(amt);
`ifdef SHL_SEQ_ROTL_EN
    u_if.in_rot   = rot;
`endif
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    u_if.in_data  = $urandom;
    u_if.in_amt   = 6'($urandom_range(0, 63));
`ifdef SHL_SEQ_ROTL_EN
    u_if.in_rot   = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic run_txn(input logic [31:0] d, input int amt, input bit rot_req, input int hold);
    int edges;
    bit rot;
    logic [31:0] exp;
    rot = rot_req && ROT_EN;
    exp = model_result(d, amt, rot);
    accept(d, amt, rot);
    edges = 1;
    if (!u_if.out_valid) begin
      check("busy_after_accept", 64'(u_if.busy), 64'd1);
      check("in_ready_after_accept", 64'(u_if.in_ready), 64'd0);
    end
    while (!u_if.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("out_valid_seen", 64'(u_if.out_valid), 64'd1);
    check("latency", 64'(edges), 64'(model_latency(amt, rot)));
    check("out_data", 64'(u_if.out_data), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 64'(u_if.out_valid), 64'd1);
      check("hold_out_data", 64'(u_if.out_data), 64'(exp));
      check("hold_in_ready", 64'(u_if.in_ready), 64'd0);
    end
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b0;
    check("drain_out_valid", 64'(u_if.out_valid), 64'd0);
    check("drain_in_ready", 64'(u_if.in_ready), 64'd1);
    check("drain_busy", 64'(u_if.busy), 64'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.in_amt    = '0;
    u_if.out_ready = 1'b0;
`ifdef SHL_SEQ_ROTL_EN
    u_if.in_rot    = 1'b0;
`endif
    #12;
    check("rst_in_ready", 64'(u_if.in_ready), 64'd1);
    check("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check("rst_out_data", 64'(u_if.out_data), 64'd0);
    check("rst_busy", 64'(u_if.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // out_ready while idle must not disturb anything
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b0;
    check("idle_out_ready_valid", 64'(u_if.out_valid), 64'd0);
    check("idle_out_ready_rdy", 64'(u_if.in_ready), 64'd1);

    run_txn(32'h12345678, 0, 1'b0, 0);
    run_txn(32'h12345678, 4, 1'b0, 0);
    run_txn(32'h12345678, 7, 1'b0, 1);
    run_txn(32'h12345678, 40, 1'b0, 3);
    run_txn(32'hFFFFFFFF, 32, 1'b0, 0);
    run_txn(32'hDEADBEEF, 31, 1'b0, 0);
    run_txn(32'h80000001, 1, 1'b1, 0);
    run_txn(32'hCAFEF00D, 32, 1'b1, 0);
    run_txn(32'hCAFEF00D, 37, 1'b1, 1);

    // Reset during the third SHIFT cycle discards the request
    accept(32'hA5A5A5A5, 32, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(u_if.out_valid), 64'd0);
    check("midrst_out_data", 64'(u_if.out_data), 64'd0);
    check("midrst_busy", 64'(u_if.busy), 64'd0);
    check("midrst_in_ready", 64'(u_if.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_out_valid", 64'(u_if.out_valid), 64'd0);
    run_txn(32'h12345678, 4, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      run_txn($urandom, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
